// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: MIPS opcode/funct constants, the symbolic request-kind enum
// shared with the decoder bench, the encoder FSM state type and small
// field-packing helpers for the three instruction formats.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FUNCT_JR = 6'b001000;

  // Codes 12..15 are deliberately left out: they are the illegal kinds.
  typedef enum logic [3:0] {
    KIND_RTYPE = 4'd0,
    KIND_ADDI  = 4'd1,
    KIND_SLTI  = 4'd2,
    KIND_BEQ   = 4'd3,
    KIND_LUI   = 4'd4,
    KIND_ORI   = 4'd5,
    KIND_BNE   = 4'd6,
    KIND_LW    = 4'd7,
    KIND_SW    = 4'd8,
    KIND_J     = 4'd9,
    KIND_JAL   = 4'd10,
    KIND_JR    = 4'd11
  } reqKind_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FULL
  } encState_t;

  function automatic logic [31:0] packR(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [5:0] funct);
    return {op, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] packI(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] packJ(input logic [5:0] op, input logic [25:0] target);
    return {op, target};
  endfunction

endpackage

// File: rtl/instr_pack.sv
// instr_pack: purely combinational packer from a symbolic request (kind plus
// register/immediate/target fields) to a 32-bit MIPS word.
// Ports:
//   kind    in  4   request kind (reqKind_t code; 12..15 are illegal)
//   rs/rt/rd in 5   register fields
//   funct   in  6   funct for RTYPE
//   imm     in  16  immediate / branch offset
//   target  in  26  jump target field
//   word    out 32  encoded instruction (0 when illegal)
//   illegal out 1   kind is not a known request
module instr_pack
  import mips_isa_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    word    = '0;
    illegal = 1'b0;
    case (kind)
      KIND_RTYPE: word = packR(OP_RTYPE, rs, rt, rd, funct);
      KIND_ADDI:  word = packI(OP_ADDI, rs, rt, imm);
      KIND_SLTI:  word = packI(OP_SLTI, rs, rt, imm);
      KIND_BEQ:   word = packI(OP_BEQ, rs, rt, imm);
      KIND_LUI:   word = packI(OP_LUI, 5'd0, rt, imm);   // LUI has no source register
      KIND_ORI:   word = packI(OP_ORI, rs, rt, imm);
      KIND_BNE:   word = packI(OP_BNE, rs, rt, imm);
      KIND_LW:    word = packI(OP_LW, rs, rt, imm);
      KIND_SW:    word = packI(OP_SW, rs, rt, imm);
      KIND_J:     word = packJ(OP_J, target);
      KIND_JAL:   word = packJ(OP_JAL, target);
      KIND_JR:    word = packR(OP_RTYPE, rs, 5'd0, 5'd0, FUNCT_JR);
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts symbolic instruction requests over valid/ready,
// packs each into a MIPS word and writes the words to consecutive
// instruction-memory addresses through a one-entry, stallable output buffer.
// Ports:
//   clk_i, rst_i (sync, active-high)
//   start_i, base_addr_i          : begin a new program at base_addr_i (word aligned)
//   req_valid_i / req_ready_o     : request handshake
//   req_kind_i, rs_i, rt_i, rd_i, funct_i, imm_i, target_i : request fields
//   imem_we_o / imem_ready_i      : write handshake to instruction memory
//   imem_addr_o, imem_wdata_o     : write address and encoded word
//   count_o, full_o, err_o        : legal words since start, limit reached, illegal seen
module instr_encoder
  import mips_isa_pkg::*;
#(
  parameter  int DEPTH  = 256,
  parameter  int ADDR_W = 32,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [3:0]        req_kind_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  input  logic [5:0]        funct_i,
  input  logic [15:0]       imm_i,
  input  logic [25:0]       target_i,
  output logic              imem_we_o,
  input  logic              imem_ready_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              err_o
);

  encState_t         state, stateNext;
  logic              bufValid;
  logic [ADDR_W-1:0] bufAddr;
  logic [31:0]       bufData;
  logic [ADDR_W-1:0] nextAddr;
  logic [CNT_W-1:0]  count;
  logic              err;
  logic [31:0]       packedWord;
  logic              packedIllegal;
  logic              accept;
  logic              acceptLegal;

  instr_pack u_pack (
    .kind    (req_kind_i),
    .rs      (rs_i),
    .rt      (rt_i),
    .rd      (rd_i),
    .funct   (funct_i),
    .imm     (imm_i),
    .target  (target_i),
    .word    (packedWord),
    .illegal (packedIllegal)
  );

  assign accept      = req_valid_i & req_ready_o;
  assign acceptLegal = accept & ~packedIllegal;

  // State register.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of process ordering.
    if (rst_i) state <= ST_IDLE;
    else       state <= stateNext;
  end

  // Next-state logic.
  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: if (start_i) stateNext = ST_RUN;
      ST_RUN: begin
        if (start_i) stateNext = ST_RUN;
        else if (acceptLegal && count == CNT_W'(DEPTH - 1)) stateNext = ST_FULL;
      end
      ST_FULL: if (start_i) stateNext = ST_RUN;
      default: stateNext = ST_IDLE;
    endcase
  end

  // Outputs. A new word can enter the buffer when it is empty or the
  // current word leaves this very cycle; start_i wins over a request.
  always_comb begin
    req_ready_o = (state == ST_RUN) && !start_i && (!bufValid || imem_ready_i);
  end

  // One-entry output buffer; the word holds until memory takes it.
  always_ff @(posedge clk_i) begin
    // NOTE: address/data registers are reset too, because the memory port
    // must read zero out of reset, not just be marked invalid.
    if (rst_i) begin
      bufValid <= 1'b0;
      bufAddr  <= '0;
      bufData  <= '0;
    end else if (acceptLegal) begin
      bufValid <= 1'b1;
      bufAddr  <= nextAddr;
      bufData  <= packedWord;
    end else if (bufValid && imem_ready_i) begin
      bufValid <= 1'b0;
    end
  end

  // Address, count and sticky error. A start leaves any buffered word alone
  // so it still completes to the address it was given.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      nextAddr <= '0;
      count    <= '0;
      err      <= 1'b0;
    end else if (start_i) begin
      nextAddr <= base_addr_i & ~ADDR_W'(3);
      count    <= '0;
      err      <= 1'b0;
    end else if (accept) begin
      if (packedIllegal) begin
        err <= 1'b1;
      end else begin
        nextAddr <= nextAddr + ADDR_W'(4);
        count    <= count + CNT_W'(1);
      end
    end
  end

  assign imem_we_o    = bufValid;
  assign imem_addr_o  = bufAddr;
  assign imem_wdata_o = bufData;
  assign count_o      = count;
  assign full_o       = (count == CNT_W'(DEPTH));
  assign err_o        = err;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic              req_valid_i;
  logic              req_ready_o;
  logic [3:0]        req_kind_i;
  logic [4:0]        rs_i, rt_i, rd_i;
  logic [5:0]        funct_i;
  logic [15:0]       imm_i;
  logic [25:0]       target_i;
  logic              imem_we_o;
  logic              imem_ready_i;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_wdata_o;
  logic [CNT_W-1:0]  count_o;
  logic              full_o;
  logic              err_o;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_kind_i   (req_kind_i),
    .rs_i         (rs_i),
    .rt_i         (rt_i),
    .rd_i         (rd_i),
    .funct_i      (funct_i),
    .imm_i        (imm_i),
    .target_i     (target_i),
    .imem_we_o    (imem_we_o),
    .imem_ready_i (imem_ready_i),
    .imem_addr_o  (imem_addr_o),
    .imem_wdata_o (imem_wdata_o),
    .count_o      (count_o),
    .full_o       (full_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int          kind;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
  } req_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         seenQ[$];
  wr_t         expQ[$];
  logic [31:0] expAddr;
  int          expCount;
  bit          expErr;
  bit          randReady = 1'b0;

  always @(posedge clk_i) cyc++;

  // Every completed memory write, sampled mid-cycle.
  always @(negedge clk_i)
    if (!rst_i && imem_we_o && imem_ready_i)
      seenQ.push_back('{imem_addr_o, imem_wdata_o, cyc});

  always @(posedge clk_i)
    if (randReady) begin
      #1 imem_ready_i = 1'($urandom_range(0, 1));
    end

  // Reference encoder straight from the instruction-format rules:
  // returns {illegal, word}.
  function automatic logic [32:0] refEncode(input req_t r);
    int unsigned op, rs, rt, rd, w;
    rs = r.rs; rt = r.rt; rd = r.rd;
    case (r.kind)
      1: op = 8;   2: op = 10;  3: op = 4;  4: op = 15; 5: op = 13;
      6: op = 5;   7: op = 35;  8: op = 43; 9: op = 2;  10: op = 3;
      default: op = 0;
    endcase
    if (r.kind > 11) return {1'b1, 32'h0};
    if (r.kind == 0)       w = rs * 2**21 + rt * 2**16 + rd * 2**11 + r.funct;
    else if (r.kind == 11) w = rs * 2**21 + 8;
    else if (r.kind >= 9)  w = op * 2**26 + r.target;
    else                   w = op * 2**26 + ((r.kind == 4) ? 0 : rs * 2**21) + rt * 2**16 + r.imm;
    return {1'b0, w};
  endfunction

  function automatic req_t mkReq(input int k, input int rs, input int rt, input int rd,
                                 input int funct, input int imm, input int target);
    req_t r;
    r.kind = k; r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd);
    r.funct = 6'(funct); r.imm = 16'(imm); r.target = 26'(target);
    return r;
  endfunction

  function automatic req_t randReq(input int maxKind);
    return mkReq($urandom_range(0, maxKind), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 65535),
                 $urandom_range(0, 2**26 - 1));
  endfunction

  task automatic modelAccept(input req_t r);
    logic [32:0] e;
    e = refEncode(r);
    if (e[32]) expErr = 1'b1;
    else begin
      expQ.push_back('{expAddr, e[31:0], 0});
      expAddr  = expAddr + 32'd4;
      expCount = expCount + 1;
    end
  endtask

  task automatic drive(input req_t r);
    req_kind_i = 4'(r.kind); rs_i = r.rs; rt_i = r.rt; rd_i = r.rd;
    funct_i = r.funct; imm_i = r.imm; target_i = r.target;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic doStart(input logic [31:0] base);
    start_i = 1'b1; base_addr_i = base;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    expAddr = base & ~32'd3; expCount = 0; expErr = 1'b0;
    expQ.delete(); seenQ.delete();
  endtask

  // Offer one request; waits at most 40 cycles for acceptance.
  task automatic sendReq(input req_t r, output bit ok);
    drive(r);
    req_valid_i = 1'b1;
    #1;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (req_ready_o) begin ok = 1'b1; break; end
      @(posedge clk_i); #2;
    end
    if (ok) begin @(posedge clk_i); #1; end
    req_valid_i = 1'b0;
    tests++;
    if (!ok) begin fails++; $display("FAIL accept_timeout kind=%0d not accepted within 40 cycles", r.kind); end
  endtask

  task automatic test_reset();
    tests++; if (req_ready_o !== 1'b0) begin fails++; $display("FAIL rst_ready got %b exp 0", req_ready_o); end
    tests++; if (imem_we_o !== 1'b0) begin fails++; $display("FAIL rst_we got %b exp 0", imem_we_o); end
    tests++; if (imem_addr_o !== 32'h0) begin fails++; $display("FAIL rst_addr got %h exp 0", imem_addr_o); end
    tests++; if (imem_wdata_o !== 32'h0) begin fails++; $display("FAIL rst_wdata got %h exp 0", imem_wdata_o); end
    tests++; if (count_o !== '0) begin fails++; $display("FAIL rst_count got %0d exp 0", count_o); end
    tests++; if (full_o !== 1'b0 || err_o !== 1'b0) begin fails++; $display("FAIL rst_flags got full=%b err=%b exp 0/0", full_o, err_o); end
    req_valid_i = 1'b1; #1;
    tests++; if (req_ready_o !== 1'b0) begin fails++; $display("FAIL idle_ready got %b exp 0", req_ready_o); end
    req_valid_i = 1'b0;
    idle(1);
  endtask

  task automatic test_directed();
    bit ok;
    logic [31:0] ea[4] = '{32'h200, 32'h204, 32'h208, 32'h20C};
    logic [31:0] ed[4] = '{32'h1022FFFF, 32'h8FA80004, 32'h0C000010, 32'h03E00008};
    doStart(32'h100);
    sendReq(mkReq(1, 0, 8, 0, 0, 5, 0), ok);
    sendReq(mkReq(0, 1, 2, 3, 6'h20, 0, 0), ok);
    idle(2);
    tests++; if (count_o !== 3'd2) begin fails++; $display("FAIL dir_count got %0d exp 2", count_o); end
    tests++;
    if (seenQ.size() != 2 || seenQ[0].addr !== 32'h100 || seenQ[0].data !== 32'h20080005 ||
        seenQ[1].addr !== 32'h104 || seenQ[1].data !== 32'h00221820) begin
      fails++;
      $display("FAIL dir_writes got n=%0d exp 2 writes {100:20080005,104:00221820}", seenQ.size());
    end
    doStart(32'h200);
    sendReq(mkReq(3, 1, 2, 0, 0, 16'hFFFF, 0), ok);
    sendReq(mkReq(7, 29, 8, 0, 0, 4, 0), ok);
    sendReq(mkReq(10, 0, 0, 0, 0, 0, 26'h10), ok);
    sendReq(mkReq(11, 31, 0, 0, 0, 0, 0), ok);
    idle(2);
    tests++; if (seenQ.size() != 4) begin fails++; $display("FAIL dir2_nwrites got %0d exp 4", seenQ.size()); end
    for (int i = 0; i < 4 && i < seenQ.size(); i++) begin
      tests++;
      if (seenQ[i].addr !== ea[i] || seenQ[i].data !== ed[i]) begin
        fails++;
        $display("FAIL dir2_word%0d got %h@%h exp %h@%h", i, seenQ[i].data, seenQ[i].addr, ed[i], ea[i]);
      end
    end
    tests++; if (full_o !== 1'b1 || count_o !== 3'd4) begin fails++; $display("FAIL dir2_full got full=%b count=%0d exp 1/4", full_o, count_o); end
  endtask

  task automatic test_stall();
    bit ok;
    req_t a, b;
    logic [32:0] ea, eb;
    a = randReq(11); b = randReq(11);
    ea = refEncode(a); eb = refEncode(b);
    doStart(32'h400);
    imem_ready_i = 1'b0;
    sendReq(a, ok);
    drive(b); req_valid_i = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (imem_we_o !== 1'b1 || imem_addr_o !== 32'h400 || imem_wdata_o !== ea[31:0] || req_ready_o !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold%0d got we=%b %h@%h rdy=%b exp 1 %h@400 rdy=0",
                 i, imem_we_o, imem_wdata_o, imem_addr_o, req_ready_o, ea[31:0]);
      end
      @(posedge clk_i); #2;
    end
    imem_ready_i = 1'b1; #1;
    tests++; if (req_ready_o !== 1'b1) begin fails++; $display("FAIL stall_release_ready got %b exp 1", req_ready_o); end
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    idle(2);
    tests++;
    if (seenQ.size() != 2 || seenQ[0].addr !== 32'h400 || seenQ[0].data !== ea[31:0] ||
        seenQ[1].addr !== 32'h404 || seenQ[1].data !== eb[31:0] || seenQ[1].cyc - seenQ[0].cyc != 1) begin
      fails++;
      $display("FAIL stall_b2b got n=%0d exp 2 consecutive writes %h@400 %h@404", seenQ.size(), ea[31:0], eb[31:0]);
    end
  endtask

  task automatic test_start_pending();
    bit ok;
    req_t c, d;
    logic [32:0] ec, ed;
    c = randReq(11); d = randReq(11);
    ec = refEncode(c); ed = refEncode(d);
    doStart(32'h500);
    imem_ready_i = 1'b0;
    sendReq(c, ok);
    start_i = 1'b1; base_addr_i = 32'h602; drive(d); req_valid_i = 1'b1; #1;
    tests++; if (req_ready_o !== 1'b0) begin fails++; $display("FAIL start_beats_valid ready got %b exp 0", req_ready_o); end
    @(posedge clk_i); #1;
    start_i = 1'b0; req_valid_i = 1'b0;
    tests++;
    if (imem_we_o !== 1'b1 || imem_addr_o !== 32'h500 || count_o !== '0) begin
      fails++;
      $display("FAIL start_pending got we=%b addr=%h count=%0d exp 1/500/0", imem_we_o, imem_addr_o, count_o);
    end
    imem_ready_i = 1'b1;
    sendReq(d, ok);
    idle(2);
    tests++;
    if (seenQ.size() != 2 || seenQ[0].addr !== 32'h500 || seenQ[0].data !== ec[31:0] ||
        seenQ[1].addr !== 32'h600 || seenQ[1].data !== ed[31:0]) begin
      fails++;
      $display("FAIL start_pending_writes got n=%0d exp %h@500 %h@600", seenQ.size(), ec[31:0], ed[31:0]);
    end
  endtask

  task automatic test_full();
    bit ok;
    req_t r;
    doStart(32'h800);
    for (int i = 0; i < DEPTH; i++) begin
      r = randReq(11);
      sendReq(r, ok);
      if (ok) modelAccept(r);
    end
    tests++; if (full_o !== 1'b1 || count_o !== 3'd4) begin fails++; $display("FAIL full_flag got full=%b count=%0d exp 1/4", full_o, count_o); end
    drive(randReq(11)); req_valid_i = 1'b1;
    idle(3); #1;
    tests++; if (req_ready_o !== 1'b0 || count_o !== 3'd4) begin fails++; $display("FAIL full_reject got ready=%b count=%0d exp 0/4", req_ready_o, count_o); end
    req_valid_i = 1'b0;
    tests++; if (seenQ.size() != expQ.size()) begin fails++; $display("FAIL full_nwrites got %0d exp %0d", seenQ.size(), expQ.size()); end
    for (int i = 0; i < expQ.size() && i < seenQ.size(); i++) begin
      tests++;
      if (seenQ[i].addr !== expQ[i].addr || seenQ[i].data !== expQ[i].data) begin
        fails++;
        $display("FAIL full_word%0d got %h@%h exp %h@%h", i, seenQ[i].data, seenQ[i].addr, expQ[i].data, expQ[i].addr);
      end
    end
    @(posedge clk_i); #1;
    doStart(32'h900);
    req_valid_i = 1'b1; #1;
    tests++;
    if (count_o !== '0 || full_o !== 1'b0 || req_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL full_restart got count=%0d full=%b ready=%b exp 0/0/1", count_o, full_o, req_ready_o);
    end
    req_valid_i = 1'b0;
  endtask

  task automatic test_illegal();
    bit ok;
    doStart(32'hA00);
    sendReq(mkReq(1, 0, 8, 0, 0, 5, 0), ok);
    sendReq(mkReq(13, 3, 4, 5, 1, 2, 3), ok);
    tests++; if (err_o !== 1'b1 || count_o !== 3'd1) begin fails++; $display("FAIL illegal_err got err=%b count=%0d exp 1/1", err_o, count_o); end
    sendReq(mkReq(1, 0, 9, 0, 0, 7, 0), ok);
    idle(2);
    tests++;
    if (seenQ.size() != 2 || seenQ[0].addr !== 32'hA00 || seenQ[0].data !== 32'h20080005 ||
        seenQ[1].addr !== 32'hA04 || seenQ[1].data !== 32'h20090007) begin
      fails++;
      $display("FAIL illegal_writes got n=%0d exp {A00:20080005,A04:20090007}", seenQ.size());
    end
    doStart(32'hB00);
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL illegal_clear got %b exp 0", err_o); end
  endtask

  task automatic test_reset_stall();
    bit ok;
    doStart(32'hC00);
    imem_ready_i = 1'b0;
    sendReq(mkReq(1, 1, 2, 0, 0, 3, 0), ok);
    tests++; if (imem_we_o !== 1'b1) begin fails++; $display("FAIL rststall_pending got we=%b exp 1", imem_we_o); end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    tests++; if (imem_we_o !== 1'b0 || count_o !== '0) begin fails++; $display("FAIL rststall_drop got we=%b count=%0d exp 0/0", imem_we_o, count_o); end
    imem_ready_i = 1'b1; req_valid_i = 1'b1;
    idle(2); #1;
    tests++;
    if (req_ready_o !== 1'b0 || seenQ.size() != 0) begin
      fails++;
      $display("FAIL rststall_idle got ready=%b writes=%0d exp 0/0", req_ready_o, seenQ.size());
    end
    req_valid_i = 1'b0;
    @(posedge clk_i); #1;
    doStart(32'hD00);
    sendReq(mkReq(4, 7, 2, 0, 0, 16'h1234, 0), ok);
    idle(2);
    tests++;
    if (seenQ.size() != 1 || seenQ[0].addr !== 32'hD00 || seenQ[0].data !== 32'h3C021234) begin
      fails++;
      $display("FAIL rststall_resume got n=%0d exp 1 write 3C021234@D00", seenQ.size());
    end
  endtask

  task automatic test_random();
    bit ok;
    req_t r;
    for (int round = 0; round < 8; round++) begin
      doStart(round == 0 ? 32'hFFFF_FFFA : $urandom);
      randReady = 1'b1;
      for (int n = 0; n < 7 && expCount < DEPTH; n++) begin
        r = randReq(15);
        sendReq(r, ok);
        if (ok) modelAccept(r);
      end
      randReady = 1'b0;
      @(posedge clk_i); #2;
      imem_ready_i = 1'b1;
      idle(3);
      tests++; if (seenQ.size() != expQ.size()) begin fails++; $display("FAIL rnd%0d_nwrites got %0d exp %0d", round, seenQ.size(), expQ.size()); end
      for (int i = 0; i < expQ.size() && i < seenQ.size(); i++) begin
        tests++;
        if (seenQ[i].addr !== expQ[i].addr || seenQ[i].data !== expQ[i].data) begin
          fails++;
          $display("FAIL rnd%0d_word%0d got %h@%h exp %h@%h", round, i, seenQ[i].data, seenQ[i].addr, expQ[i].data, expQ[i].addr);
        end
      end
      tests++;
      if (count_o !== 3'(expCount) || err_o !== expErr || full_o !== (expCount == DEPTH)) begin
        fails++;
        $display("FAIL rnd%0d_status got count=%0d err=%b full=%b exp %0d/%b/%b",
                 round, count_o, err_o, full_o, expCount, expErr, expCount == DEPTH);
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; req_valid_i = 1'b0;
    req_kind_i = '0; rs_i = '0; rt_i = '0; rd_i = '0; funct_i = '0; imm_i = '0; target_i = '0;
    imem_ready_i = 1'b1;
    expAddr = '0; expCount = 0; expErr = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    test_reset();
    test_directed();
    test_stall();
    test_start_pending();
    test_full();
    test_illegal();
    test_reset_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish within 300000 time units");
    $fatal(1);
  end

endmodule
